// File: rtl/seq_long_divider.sv
// Sequential unsigned restoring divider that produces one quotient bit per clock.
// Optional debug outputs are enabled by defining SEQ_LONG_DIV_DEBUG_EN.
module seq_long_divider #(
    parameter int unsigned DW = 8,
    parameter int unsigned MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] D,
    input  logic [MW-1:0] M,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [MW-1:0] R,
    output logic          div_by_zero
`ifdef SEQ_LONG_DIV_DEBUG_EN
    ,
    output logic [MW:0]                debug_partial_rem,
    output logic [$clog2(DW+1)-1:0]    debug_step
`endif
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, next_state;

    logic [DW-1:0] dvd;
    logic [MW-1:0] dvs;
    logic [MW:0]   pr;
    logic [CW-1:0] step;

    logic [MW+1:0] pr_sh;
    logic [MW+1:0] trial;
    logic [MW:0]   pr_next;
    logic          qbit;
    logic          accept;
    logic          last;

    // One extra guard bit above PR makes the subtraction's top bit a clean borrow flag.
    always_comb begin
        pr_sh   = {pr, dvd[DW-1]};
        trial   = pr_sh - {2'b00, dvs};
        qbit    = ~trial[MW+1];
        pr_next = qbit ? trial[MW:0] : pr_sh[MW:0];
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start && (M != '0)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (step == LAST) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            pr          <= '0;
            step        <= '0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dvd  <= D;
                dvs  <= M;
                pr   <= '0;
                step <= '0;
                if (M == '0) begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    Q           <= '1;
                    R           <= '0;
                end
            end else if (state == RUN) begin
                // Quotient bits fill the dividend register from the LSB as it drains.
                dvd  <= {dvd[DW-2:0], qbit};
                pr   <= pr_next;
                step <= step + 1'b1;
                if (last) begin
                    Q           <= {dvd[DW-2:0], qbit};
                    R           <= pr_next[MW-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    step        <= '0;
                end
            end
        end
    end

    assign busy = (state == RUN);

`ifdef SEQ_LONG_DIV_DEBUG_EN
    assign debug_partial_rem = pr;
    assign debug_step        = step;
`endif

endmodule

// File: tb/tb_seq_long_divider.sv
// Self-checking bench for seq_long_divider against an arithmetic reference model.
// Debug ports are connected only when SEQ_LONG_DIV_DEBUG_EN is defined.
module tb_seq_long_divider;

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 4;
    localparam int unsigned TIMEOUT = 40;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] D;
    logic [MW-1:0] M;
    logic          busy;
    logic          done;
    logic [DW-1:0] Q;
    logic [MW-1:0] R;
    logic          div_by_zero;
`ifdef SEQ_LONG_DIV_DEBUG_EN
    logic [MW:0]             debug_partial_rem;
    logic [$clog2(DW+1)-1:0] debug_step;
`endif

    int checks = 0;
    int errors = 0;

    seq_long_divider #(.DW(DW), .MW(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .D           (D),
        .M           (M),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
`ifdef SEQ_LONG_DIV_DEBUG_EN
        ,
        .debug_partial_rem (debug_partial_rem),
        .debug_step        (debug_step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division; zero divisor gives all-ones quotient.
    function automatic void ref_div(input int unsigned d, input int unsigned m,
                                    output int unsigned q, output int unsigned r,
                                    output bit z);
        if (m == 0) begin
            q = (1 << DW) - 1;
            r = 0;
            z = 1'b1;
        end else begin
            q = d / m;
            r = d % m;
            z = 1'b0;
        end
    endfunction

    // Issue one request and wait for done; lat = edges after the accepting edge.
    task automatic issue(input int unsigned d, input int unsigned m,
                         output int unsigned lat, output bit busy0);
        @(negedge clk);
        D     = DW'(d);
        M     = MW'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input int unsigned d, input int unsigned m,
                                input int unsigned lat, input bit busy0);
        int unsigned eq, er, elat;
        bit ez, ebusy;
        ref_div(d, m, eq, er, ez);
        elat  = (m == 0) ? 0 : DW;
        ebusy = (m != 0);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency d=%0d m=%0d got %0d expected %0d", name, d, m, lat, elat);
        end
        checks++;
        if ({done, busy, Q, R, div_by_zero} !== {1'b1, 1'b0, DW'(eq), MW'(er), ez}) begin
            errors++;
            $display("FAIL %s result d=%0d m=%0d got done=%0b busy=%0b Q=%0d R=%0d z=%0b expected done=1 busy=0 Q=%0d R=%0d z=%0b",
                     name, d, m, done, busy, Q, R, div_by_zero, eq, er, ez);
        end
        checks++;
        if (busy0 !== ebusy) begin
            errors++;
            $display("FAIL %s busy_after_start d=%0d m=%0d got %0b expected %0b", name, d, m, busy0, ebusy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        D     = '0;
        M     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, Q, R, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%0b done=%0b Q=%0d R=%0d z=%0b expected all 0",
                     busy, done, Q, R, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        int unsigned tv_d[5] = '{7, 200, 255, 9, 0};
        int unsigned tv_m[5] = '{2, 13, 1, 15, 6};
        int unsigned lat;
        bit b0;
        for (int i = 0; i < 5; i++) begin
            issue(tv_d[i], tv_m[i], lat, b0);
            check_result("directed", tv_d[i], tv_m[i], lat, b0);
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width got %0b expected 0", done);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int unsigned lat;
        bit b0;
        issue(5, 0, lat, b0);
        check_result("div_by_zero", 5, 0, lat, b0);
        @(negedge clk);
        checks++;
        if ({done, busy, Q, R, div_by_zero} !== {1'b0, 1'b0, 8'hFF, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL dbz_hold got done=%0b busy=%0b Q=%0d R=%0d z=%0b expected done=0 busy=0 Q=255 R=0 z=1",
                     done, busy, Q, R, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int unsigned lat;
        bit b0;
        @(negedge clk);
        D = 8'd12; M = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        D = 8'd6; M = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check_result("b2b_first", 12, 5, lat, 1'b1);
        // Next request issued in the done cycle itself.
        D = 8'd6; M = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b0  = busy;
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check_result("b2b_second", 6, 2, lat, b0);
    endtask

    task automatic test_reset_mid_op;
        int unsigned lat;
        bit b0;
        bit saw_done;
        @(negedge clk);
        D = 8'd100; M = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Q, R, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op got busy=%0b done=%0b Q=%0d R=%0d z=%0b expected all 0",
                     busy, done, Q, R, div_by_zero);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got activity=%0b expected 0", saw_done);
        end
        issue(100, 7, lat, b0);
        check_result("after_reset", 100, 7, lat, b0);
    endtask

    task automatic test_sweep;
        int unsigned lat;
        bit b0;
        for (int unsigned m = 1; m < 16; m++) begin
            for (int unsigned d = 0; d < 256; d++) begin
                issue(d, m, lat, b0);
                checks++;
                if (lat !== DW || done !== 1'b1 || div_by_zero !== 1'b0 ||
                    (32'(Q) * m + 32'(R)) !== d || 32'(R) >= m) begin
                    errors++;
                    $display("FAIL sweep d=%0d m=%0d got Q=%0d R=%0d z=%0b lat=%0d expected Q*M+R=D, R<M, z=0, lat=%0d",
                             d, m, Q, R, div_by_zero, lat, DW);
                end
            end
        end
    endtask

    task automatic test_random;
        int unsigned d, m, lat;
        bit b0;
        for (int i = 0; i < 300; i++) begin
            d = $urandom_range(255, 0);
            m = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(15, 1);
            issue(d, m, lat, b0);
            check_result("random", d, m, lat, b0);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_by_zero;
        test_back_to_back;
        test_reset_mid_op;
        test_sweep;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_long_divider.md
Name: seq_long_divider

Overview:
Parametrised, multi-cycle unsigned long divider. It is the sequential successor to the combinational CAS-array long_divider: widths are generic and it resolves one quotient bit per clock using restoring division. A start/busy/done handshake is added, plus divide-by-zero detection. It sits in the datapath wherever a small-area divider is preferred over a full array.

Parameters:
DW, 8, dividend and quotient width in bits (>=2)
MW, 4, divisor and remainder width in bits (>=1, MW<=DW)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only while busy=0
D  input  DW  dividend, captured on accepted start
M  input  MW  divisor, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when Q/R/div_by_zero are updated
Q  output  DW  quotient, registered, held until next done
R  output  MW  remainder, registered, held until next done
div_by_zero  output  1  set with done when captured M==0; held until next done

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; internal PR, shift register and counter all cleared.
- States: IDLE, RUN.
- IDLE + start=1 at edge E0: capture D into shift register and M into divisor register. Clear PR (MW+1 bits) and step counter.
  - If M!=0: go to RUN, busy=1.
  - If M==0: stay IDLE. At E0 set done=1, div_by_zero=1, Q=all ones, R=0. Latency 1 cycle; busy never asserts.
- RUN, each edge (DW edges, E1..EDW):
  - PR={PR[MW-1:0], dividend MSB}; shift dividend left.
  - trial=PR-{1'b0,M} at MW+1 bits.
  - If no borrow: PR=trial, quotient bit=1; else quotient bit=0.
  - Quotient bits shift in LSB-first into the vacated dividend bits, so no separate Q register is needed during RUN.
- At EDW: load Q=quotient and R=PR[MW-1:0], div_by_zero=0, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start accepted at E0 -> done high in cycle after EDW (DW cycles).
- Throughput: a start asserted in the same cycle done is high is accepted (back-to-back issue, one division per DW+1 cycles minimum... exactly DW cycles start-to-done, next start legal the cycle done is high).
- start while busy=1 is ignored; inputs D/M are not sampled during RUN.
- Invariant: R < M always for M!=0; Q*M+R==D.
- D=0: Q=0, R=0 after DW cycles; no early exit.
- rst_n asserted mid-RUN: immediate abort to reset values; no done pulse.

Optional Feature:
Macro SEQ_LONG_DIV_DEBUG_EN.
- Defined: adds two outputs.
  - debug_partial_rem [MW:0] shows the live PR register.
  - debug_step [$clog2(DW+1)-1:0] shows the current step count, 0 in IDLE.
  - Both are reset to 0.
- Undefined: these ports and their logic are absent; the functional behaviour is identical.

Test Plan:
- DW=8, MW=4; D=7, M=2, start pulse -> busy 8 cycles; done pulse with Q=3, R=1, div_by_zero=0.
- D=200, M=13 -> Q=15, R=5. D=255, M=1 -> Q=255, R=0. D=9, M=15 -> Q=0, R=9. All complete 8 cycles after start.
- D=5, M=0 -> done one cycle after start, busy stays 0; Q=8'hFF, R=0, div_by_zero=1.
- Back-to-back: start(12/5) then, during busy, start(6/2) -> second request ignored, first gives Q=2, R=2. New start(6/2) in the done cycle -> Q=3, R=0 exactly 8 cycles later.
- Reset mid-op: start 100/7, drop rst_n after 3 cycles -> all outputs 0 at once, no done. Release reset, start 100/7 -> Q=14, R=2.
- Randomised sweep of all D in 0..255, M in 1..15 -> Q*M+R==D and R<M for every result, checked on each done.
